// File: rtl/mic_pkg.sv
// Shared types, constants and the output saturation helper for the mic DC-block packer.
package mic_pkg;

    localparam int unsigned MIC_DW    = 24;
    localparam int unsigned MIC_NCH   = 6;
    localparam int unsigned MIC_CH_W  = 3;
    localparam int unsigned MIC_SUM_W = MIC_DW + 3;

    typedef logic signed [MIC_DW-1:0] mic_sample_t;

    typedef struct packed {
        mic_sample_t         data;
        logic [MIC_CH_W-1:0] ch;
        logic                sof;
        logic                eof;
    } mic_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PROC = 1'b1
    } mic_state_t;

    // Clamp the wide filter sum back to the sample range.
    function automatic mic_sample_t sat_dw(input logic signed [MIC_SUM_W-1:0] s);
        if (s[MIC_SUM_W-1:MIC_DW-1] == {(MIC_SUM_W-MIC_DW+1){s[MIC_SUM_W-1]}})
            return s[MIC_DW-1:0];
        else if (s[MIC_SUM_W-1])
            return {1'b1, {(MIC_DW-1){1'b0}}};
        else
            return {1'b0, {(MIC_DW-1){1'b1}}};
    endfunction

endpackage

// File: rtl/mic_dc_block_packer_if.sv
// Frame input and word-stream output bundle of the mic DC-block packer.
interface mic_dc_block_packer_if #(parameter int unsigned DW = 24) ();

    logic                 in_vld;
    logic signed [DW-1:0] mic0_data;
    logic signed [DW-1:0] mic1_data;
    logic signed [DW-1:0] mic2_data;
    logic signed [DW-1:0] mic3_data;
    logic signed [DW-1:0] mic4_data;
    logic signed [DW-1:0] mic5_data;
    logic                 dc_en;
    logic                 out_ready;
    logic                 out_vld;
    logic signed [DW-1:0] out_data;
    logic [2:0]           out_ch;
    logic                 out_sof;
    logic                 out_eof;

    modport master (
        output in_vld, mic0_data, mic1_data, mic2_data, mic3_data, mic4_data, mic5_data,
        output dc_en, out_ready,
        input  out_vld, out_data, out_ch, out_sof, out_eof
    );

    modport slave (
        input  in_vld, mic0_data, mic1_data, mic2_data, mic3_data, mic4_data, mic5_data,
        input  dc_en, out_ready,
        output out_vld, out_data, out_ch, out_sof, out_eof
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port and a registered occupancy count.
module sync_fifo #(
    parameter int unsigned W     = 29,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd_ready,
    output logic [W-1:0]  rdata,
    output logic          rvld,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   mem_cnt;
    logic pop_c, load_c, mem_rd_c, bypass_c, mem_wr_c;

    // The output register refills when empty or being popped; an empty array lets a write go straight through.
    always_comb begin
        pop_c    = rvld & rd_ready;
        load_c   = ~rvld | pop_c;
        mem_rd_c = load_c & (mem_cnt != '0);
        bypass_c = load_c & (mem_cnt == '0) & wr;
        mem_wr_c = wr & ~bypass_c;
    end

    always_ff @(posedge clk) begin
        if (mem_wr_c) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            count   <= '0;
            rdata   <= '0;
            rvld    <= 1'b0;
        end else begin
            if (mem_wr_c) wr_ptr <= wr_ptr + AW'(1);
            if (mem_rd_c) rd_ptr <= rd_ptr + AW'(1);
            mem_cnt <= mem_cnt + (AW+1)'(mem_wr_c) - (AW+1)'(mem_rd_c);
            count   <= count + CW'(wr) - CW'(pop_c);
            if (load_c) begin
                if (mem_rd_c) begin
                    rdata <= mem[rd_ptr];
                    rvld  <= 1'b1;
                end else if (bypass_c) begin
                    rdata <= wdata;
                    rvld  <= 1'b1;
                end else begin
                    rvld  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mic_dc_block_packer.sv
// Six-channel DC-blocking high-pass filter on one shared datapath, serialised into a word FIFO.
module mic_dc_block_packer
    import mic_pkg::*;
#(
    parameter int unsigned DW         = 24,
    parameter int unsigned K          = 10,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mic_dc_block_packer_if.slave  bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int unsigned FCW     = $clog2(FIFO_DEPTH) + 2;
    localparam int unsigned WORD_W  = $bits(mic_word_t);
    localparam int unsigned LAST_CH = MIC_NCH - 1;

    mic_state_t state, state_nxt;
    logic [MIC_CH_W-1:0] ch_idx;
    mic_sample_t x_lat  [MIC_NCH];
    mic_sample_t x_prev [MIC_NCH];
    mic_sample_t y_prev [MIC_NCH];
    mic_sample_t x_in_c [MIC_NCH];
    logic        en_lat;

    logic accept_c, drop_c, wr_c;
    mic_word_t wdata_c, rword;
    logic [FCW-1:0] fifo_cnt;
    logic fifo_vld;

    mic_sample_t x_sel_c, xp_sel_c, yp_sel_c, t_c, y_c;
    logic signed [DW:0]   d_c;
    logic signed [DW+2:0] s_c;

    always_comb begin
        x_in_c[0] = bus.mic0_data;
        x_in_c[1] = bus.mic1_data;
        x_in_c[2] = bus.mic2_data;
        x_in_c[3] = bus.mic3_data;
        x_in_c[4] = bus.mic4_data;
        x_in_c[5] = bus.mic5_data;
    end

    // Next state, frame accept/drop decision and the time-shared filter datapath.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        drop_c    = 1'b0;
        wr_c      = 1'b0;
        wdata_c   = '0;
        x_sel_c   = x_lat[ch_idx];
        xp_sel_c  = x_prev[ch_idx];
        yp_sel_c  = y_prev[ch_idx];
        d_c       = (DW+1)'(x_sel_c) - (DW+1)'(xp_sel_c);
        t_c       = yp_sel_c - (yp_sel_c >>> K);
        s_c       = (DW+3)'(d_c) + (DW+3)'(t_c);
        y_c       = en_lat ? sat_dw(s_c) : x_sel_c;
        case (state)
            ST_IDLE: begin
                if (bus.in_vld) begin
                    if (fifo_cnt <= FCW'(FIFO_DEPTH - MIC_NCH)) begin
                        accept_c  = 1'b1;
                        state_nxt = ST_PROC;
                    end else begin
                        drop_c = 1'b1;
                    end
                end
            end
            ST_PROC: begin
                drop_c       = bus.in_vld;
                wr_c         = 1'b1;
                wdata_c.data = y_c;
                wdata_c.ch   = ch_idx;
                wdata_c.sof  = (ch_idx == '0);
                wdata_c.eof  = (ch_idx == MIC_CH_W'(LAST_CH));
                if (ch_idx == MIC_CH_W'(LAST_CH)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_PROC);
            if (drop_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // Frame latch plus per-channel filter history; bypass clears y history so re-enable starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_idx <= '0;
            en_lat <= 1'b0;
            for (int i = 0; i < MIC_NCH; i++) begin
                x_lat[i]  <= '0;
                x_prev[i] <= '0;
                y_prev[i] <= '0;
            end
        end else if (accept_c) begin
            ch_idx <= '0;
            en_lat <= bus.dc_en;
            for (int i = 0; i < MIC_NCH; i++) x_lat[i] <= x_in_c[i];
        end else if (state == ST_PROC) begin
            ch_idx         <= ch_idx + MIC_CH_W'(1);
            x_prev[ch_idx] <= x_sel_c;
            y_prev[ch_idx] <= en_lat ? y_c : '0;
        end
    end

    sync_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr_c),
        .wdata    (wdata_c),
        .rd_ready (bus.out_ready),
        .rdata    (rword),
        .rvld     (fifo_vld),
        .count    (fifo_cnt)
    );

    assign bus.out_vld  = fifo_vld;
    assign bus.out_data = rword.data;
    assign bus.out_ch   = rword.ch;
    assign bus.out_sof  = rword.sof;
    assign bus.out_eof  = rword.eof;

endmodule

// File: tb/tb_mic_dc_block_packer.sv
// Directed bench for mic_dc_block_packer: filter values, bypass, drops, backpressure and reset.
module tb_mic_dc_block_packer;
    import mic_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [15:0] drop_cnt;
    int n_cmp = 0;
    int n_err = 0;
    mic_word_t mon_q [$];

    mic_dc_block_packer_if #(.DW(24)) bus ();

    mic_dc_block_packer #(.DW(24), .K(2), .FIFO_DEPTH(16), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Accepted output words, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && bus.out_vld && bus.out_ready)
            mon_q.push_back('{data: bus.out_data, ch: bus.out_ch, sof: bus.out_sof, eof: bus.out_eof});
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_vld    = 1'b0;
        bus.dc_en     = 1'b0;
        bus.out_ready = 1'b1;
        bus.mic0_data = '0; bus.mic1_data = '0; bus.mic2_data = '0;
        bus.mic3_data = '0; bus.mic4_data = '0; bus.mic5_data = '0;
        tick(3);
        rst_n = 1'b1;
        mon_q.delete();
        tick(2);
    endtask

    // Presents one frame for exactly one clock; returns just after the sampling edge.
    task automatic send(input int x[6], input logic en);
        bus.mic0_data = 24'(x[0]); bus.mic1_data = 24'(x[1]); bus.mic2_data = 24'(x[2]);
        bus.mic3_data = 24'(x[3]); bus.mic4_data = 24'(x[4]); bus.mic5_data = 24'(x[5]);
        bus.dc_en  = en;
        bus.in_vld = 1'b1;
        tick(1);
        bus.in_vld = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int exp[6]);
        mic_word_t w;
        mic_sample_t d;
        chk({tag, "_avail"}, 32'(mon_q.size() >= 6), 32'sd1);
        if (mon_q.size() < 6) return;
        for (int c = 0; c < 6; c++) begin
            w = mon_q.pop_front();
            d = w.data;
            chk($sformatf("%s_data%0d", tag, c), d, exp[c]);
            chk($sformatf("%s_ch%0d", tag, c), 32'(w.ch), c);
            chk($sformatf("%s_sof%0d", tag, c), 32'(w.sof), 32'(c == 0));
            chk($sformatf("%s_eof%0d", tag, c), 32'(w.eof), 32'(c == 5));
        end
    endtask

    initial begin
        int x[6];
        int e[6];
        mic_sample_t d;

        do_reset();
        chk("rst_vld", 32'(bus.out_vld), 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_ch", 32'(bus.out_ch), 0);
        chk("rst_sof", 32'(bus.out_sof), 0);
        chk("rst_eof", 32'(bus.out_eof), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // DC step of 1000 decays as 1000, 750, 563 with K=2.
        x = '{1000, 1000, 1000, 1000, 1000, 1000};
        send(x, 1'b1);
        chk("busy_t1", 32'(busy), 1);
        tick(5);
        chk("busy_t6", 32'(busy), 1);
        tick(1);
        chk("busy_t7", 32'(busy), 0);
        tick(57);
        send(x, 1'b1);
        tick(63);
        send(x, 1'b1);
        tick(63);
        chk("dc_count", 32'(mon_q.size()), 18);
        chk_frame("dc_f1", '{1000, 1000, 1000, 1000, 1000, 1000});
        chk_frame("dc_f2", '{750, 750, 750, 750, 750, 750});
        chk_frame("dc_f3", '{563, 563, 563, 563, 563, 563});

        // Saturation at both rails on ch0.
        do_reset();
        send('{-8388608, 0, 0, 0, 0, 0}, 1'b1);
        tick(20);
        send('{8388607, 0, 0, 0, 0, 0}, 1'b1);
        tick(20);
        chk_frame("sat_f1", '{-8388608, 0, 0, 0, 0, 0});
        chk_frame("sat_f2", '{8388607, 0, 0, 0, 0, 0});

        // Bypass passes samples through; re-enabling on the same input gives zero.
        do_reset();
        x = '{700, 701, 702, 703, 704, 705};
        send(x, 1'b0);
        tick(20);
        send(x, 1'b1);
        tick(20);
        chk_frame("byp", '{700, 701, 702, 703, 704, 705});
        chk_frame("byp_en", '{0, 0, 0, 0, 0, 0});

        // Second strobe while busy is dropped whole.
        do_reset();
        send('{300, 300, 300, 300, 300, 300}, 1'b1);
        tick(2);
        send('{999, 999, 999, 999, 999, 999}, 1'b1);
        tick(30);
        chk("col_drop", 32'(drop_cnt), 1);
        chk("col_count", 32'(mon_q.size()), 6);
        chk_frame("col", '{300, 300, 300, 300, 300, 300});

        // Stalled consumer: only two frames fit, output holds, then drains in order.
        do_reset();
        bus.out_ready = 1'b0;
        send('{100, 101, 102, 103, 104, 105}, 1'b0);
        tick(7);
        send('{200, 201, 202, 203, 204, 205}, 1'b0);
        tick(7);
        send('{300, 301, 302, 303, 304, 305}, 1'b1);
        tick(7);
        send('{400, 401, 402, 403, 404, 405}, 1'b1);
        tick(7);
        chk("bp_drop", 32'(drop_cnt), 2);
        chk("bp_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_vld%0d", i), 32'(bus.out_vld), 1);
            chk($sformatf("bp_hold_data%0d", i), bus.out_data, 100);
            chk($sformatf("bp_hold_ch%0d", i), 32'(bus.out_ch), 0);
            chk($sformatf("bp_hold_sof%0d", i), 32'(bus.out_sof), 1);
        end
        tick(1);
        bus.out_ready = 1'b1;
        tick(20);
        chk("bp_count", 32'(mon_q.size()), 12);
        chk_frame("bp_f1", '{100, 101, 102, 103, 104, 105});
        chk_frame("bp_f2", '{200, 201, 202, 203, 204, 205});
        // Dropped frames left the filter history untouched, so this frame yields zero.
        send('{200, 201, 202, 203, 204, 205}, 1'b1);
        tick(15);
        chk_frame("bp_after", '{0, 0, 0, 0, 0, 0});

        // Reset mid-frame clears the FIFO and the filter history.
        do_reset();
        send('{777, 777, 777, 777, 777, 777}, 1'b1);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", 32'(bus.out_vld), 0);
        chk("mrst_busy", 32'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        mon_q.delete();
        tick(2);
        chk("mrst_idle_vld", 32'(bus.out_vld), 0);
        send('{500, 500, 500, 500, 500, 500}, 1'b1);
        tick(15);
        chk("mrst_count", 32'(mon_q.size()), 6);
        chk_frame("mrst", '{500, 500, 500, 500, 500, 500});
        d = bus.out_data;
        chk("mrst_last", d, 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mic_dc_block_packer.md
Name: mic_dc_block_packer

Overview:
- Downstream stage of the I2S microphone front end.
- Accepts one 6-channel frame of 24-bit signed samples per valid pulse: mic0/1 are the left/right slots of data line 0, mic2/3 of line 1, mic4/5 of line 2.
- Removes DC on each channel with a first-order high-pass IIR, using one shared, time-multiplexed datapath.
- Serializes results into a word stream (ch0..ch5) through an output FIFO with a valid/ready handshake. This stream feeds beamforming/packetizing logic.

Parameters:
- DW, 24, sample width (input and output)
- K, 10, IIR pole shift; pole a = 1 - 2^-K. Legal range 1..15.
- FIFO_DEPTH, 16, output FIFO depth in words. Power of two, >= 8.
- CNT_W, 16, drop counter width

Ports:
- clk, in, 1, block clock; the mic bit clock domain. All sequential logic runs on posedge clk.
- rst_n, in, 1, asynchronous active-low reset
- in_vld, in, 1, single-cycle frame strobe
- mic0_data .. mic5_data, in, DW each, signed samples; sampled only when in_vld=1
- dc_en, in, 1, 1 = filter enabled, 0 = bypass. Sampled at frame accept.
- out_ready, in, 1, consumer ready
- out_vld, out, 1, out_data / out_ch / out_sof / out_eof are valid
- out_data, out, DW, filtered signed sample
- out_ch, out, 3, channel index 0..5
- out_sof, out, 1, high with ch0
- out_eof, out, 1, high with ch5
- busy, out, 1, FSM not in IDLE
- drop_cnt, out, CNT_W, count of dropped frames; saturates at all-ones

Behaviour:
- Reset: async on rst_n low.
  - Outputs: out_vld=0, out_data=0, out_ch=0, out_sof=0, out_eof=0, busy=0, drop_cnt=0.
  - Internal state: FIFO emptied; all x_prev/y_prev cleared to 0; FSM goes to IDLE.
  - Reset mid-frame: any partially written frame is discarded, because the FIFO is cleared.
- FSM has two states: IDLE and PROC.
- Frame accept rule: a frame is accepted when in_vld=1 and state=IDLE and FIFO free entries >= 6.
  - On accept, latch all six samples plus dc_en, set ch_idx=0, go to PROC.
- Frame drop rule: if in_vld=1 and the frame is not accepted (busy, or fewer than 6 free entries), the frame is dropped.
  - drop_cnt increments by 1, saturating.
  - Filter state is not updated.
- PROC: one channel per cycle, ch_idx = 0..5. Each cycle writes one FIFO word {data, ch, sof=(ch==0), eof=(ch==5)}. After ch5, return to IDLE.
  - Accept at cycle T -> FIFO writes at T+1..T+6 -> busy high T+1..T+6.
  - An in_vld at T+7 can be accepted.
- Filter arithmetic, per channel c, with signed extension throughout:
  - d = x - x_prev[c], computed at DW+1 bits
  - t = y_prev[c] - (y_prev[c] >>> K), arithmetic shift
  - s = d + t, computed at DW+3 bits
  - y = sat_DW(s): clamp to [-2^(DW-1), 2^(DW-1)-1]
  - Updates: x_prev[c] <= x; y_prev[c] <= y
  - Output word = y
- Bypass (dc_en=0): output word = x; x_prev[c] <= x; y_prev[c] <= 0.
- Output FIFO:
  - Registered read port. out_vld goes high the cycle after the first write into an empty FIFO.
  - A word is popped on out_vld & out_ready.
  - Simultaneous write and read are supported.
  - The FIFO never overflows, because free space is checked at accept and reads only increase it.
  - While out_vld=1 and out_ready=0, out_* hold stable.
- The consumer may stall indefinitely. Frames are then dropped whole, never split; SOF..EOF sequences are always complete.

Decomposition:
- Package mic_pkg:
  - typedef mic_sample_t (logic signed [23:0])
  - typedef mic_word_t (struct: data, ch, sof, eof)
  - constant MIC_NCH=6
  - function sat_dw()
- Sub-module: sync_fifo (single-clock, registered output, count output), instantiated for the output FIFO. Width = $bits(mic_word_t).

Test Plan:
- Reset, K=2, dc_en=1, all channels x=1000 for 3 frames spaced 64 cycles, out_ready=1 -> per channel, outputs are 1000, 750, 563. out_ch sequence 0..5 each frame; sof on ch0, eof on ch5.
- Saturation, K=2, ch0: frame1 x=-8388608 -> out -8388608; frame2 x=8388607 -> d=16777215, t=-6291456, s=10485759 -> out 0x7FFFFF.
- dc_en=0, x=k*100+c (c = channel index) -> out_data equals input exactly. A later frame with dc_en=1 and the same x -> y=0, because d=0 and y_prev=0.
- Busy collision: in_vld at T and T+3 -> second frame dropped, drop_cnt=1, exactly 6 words out.
- Backpressure, FIFO_DEPTH=16: out_ready=0, 4 frames -> frames 1-2 accepted, frames 3-4 dropped, drop_cnt=2. Then release out_ready -> 12 words in order, out_* held stable during the stall.
- Reset asserted at T+3 of a frame -> out_vld=0 immediately. After release, first frame with x=500 outputs 500, showing the state was cleared.
